tennis_scoreboard: RTL and testbench
====================================

// Module: tennis_scoreboard
// PURPOSE
//  Receive-side companion to the tennis ball engine: watches the 16-bit LED ball bus and turns it into game events.
//  Decodes ball position and direction, detects returns (hits), points and the win banners.
//  Keeps per-player scores and a BCD rally counter for the display logic.
//  Runs on the same divided game clock as the ball engine and samples the bus once per game tick.
// PARAMETERS
//  WIN_POINTS  3   points that end a match; scores saturate here
//  RALLY_MAX   99  BCD rally counter saturation value (2 digits)
// PORTS
//  newclock      in   1   divided game clock, rising edge
//  reset         in   1   asynchronous, active-high
//  ball          in   16  LED ball bus; one-hot = ball position; bit 0 = right end, bit 15 = left end
//  pos           out  4   index of the lit bit in the last valid one-hot sample
//  pos_valid     out  1   last sample was one-hot
//  dir           out  1   1 = moving toward bit 15 (left), 0 = toward bit 0 (right)
//  hit_left      out  1   1-tick pulse: left player returned the ball at bit 15
//  hit_right     out  1   1-tick pulse: right player returned the ball at bit 0
//  point_left    out  1   1-tick pulse: left player won a point
//  point_right   out  1   1-tick pulse: right player won a point
//  score_left    out  2   left points, 0..WIN_POINTS
//  score_right   out  2   right points, 0..WIN_POINTS
//  rally_bcd     out  8   returns in current rally, 2-digit BCD, saturates at 8'h99
//  match_over    out  1   match finished, held until cleared
//  match_winner  out  1   1 = left won, 0 = right won; valid while match_over
//  err           out  1   last sample illegal (zero, or multi-hot other than a banner)
// BEHAVIOUR
//  Reset values:
//   - pos=0, pos_valid=0, dir=1, all pulses 0.
//   - Scores 0, rally_bcd=8'h00, match_over=0, match_winner=0, err=0.
//   - State IDLE, prev_pos=0.
//  Timing:
//   - All outputs are registered.
//   - Each output reflects the ball value sampled at the previous newclock edge: 1-tick latency.
//   - Pulses are high for exactly one newclock period.
//  Sample classes:
//   - One-hot: pos_valid=1 and pos=index.
//   - 16'h0801: right-win banner.
//   - 16'h4010: left-win banner.
//   - Anything else: err=1 for that tick; all other state is held. err clears on the next legal sample.
//  Moves (one-hot sample vs prev_pos):
//   - adjacent = |pos-prev_pos|==1; adjacent+1 sets dir=1, adjacent-1 sets dir=0.
//   - stationary = same index; dir is held.
//   - jump = any other index.
//   - prev_pos updates on every one-hot sample.
//  FSM states: IDLE, RALLY, POINT, MATCH.
//   IDLE:
//     - Adjacent move -> RALLY, rally_bcd cleared to 0.
//     - Stationary or jump: stay in IDLE.
//   RALLY:
//     - dir flips 1->0 with prev_pos=15 -> hit_left, rally_bcd+1.
//     - dir flips 0->1 with prev_pos=0 -> hit_right, rally_bcd+1.
//     - Stationary at 15, or jump to 0 -> point_right, score_right+1, -> POINT.
//     - Stationary at 0, or jump to 15 -> point_left, score_left+1, -> POINT.
//     - Stationary at any other position: stay in RALLY, no event.
//   POINT:
//     - Unconditionally -> IDLE on the next tick.
//     - If the score just written equals WIN_POINTS -> MATCH instead, with match_over=1 and match_winner = scorer.
//   Any state, on a banner sample:
//     - match_over=1, match_winner from the banner, -> MATCH.
//     - The banner overrides the winner already latched.
//   MATCH:
//     - Ignores moves; pulses stay low.
//     - First one-hot sample after a banner has been seen clears scores, rally_bcd, match_over and match_winner, then -> IDLE.
//     - Without a banner it stays in MATCH indefinitely.
//  Arithmetic:
//   - Scores saturate at WIN_POINTS.
//   - rally_bcd counts as a decimal carry chain (8'h09 -> 8'h10) and saturates at 8'h99.
//  Reset mid-match or mid-rally: all state returns to reset values immediately (asynchronous).
// TESTING
//  1. Reset, ball=0x0001 held 3 ticks, then shifted left 1 bit/tick -> IDLE, then RALLY at 0x0002; dir=1, pos tracks 1..15.
//  2. Ball reaches 0x8000, then 0x4000 -> hit_left one pulse, rally_bcd=8'h01, dir=0.
//  3. Ball 0x8000 held 2 ticks in RALLY -> point_right pulse, score_right=1, state IDLE after POINT.
//  4. Three right points -> match_over=1, match_winner=0; then 0x0801, then 0x0001 -> scores=0, match_over=0.
//  5. Ball=0x4010 mid-rally -> match_over=1, match_winner=1; ball=0x0003 -> err=1, scores held.
//  6. Force 10 alternating returns -> rally_bcd=8'h10; assert reset mid-rally -> all outputs at reset values.

Source files
------------

// File: rtl/tennis_scoreboard_if.sv
// Ball bus and scoreboard outputs shared between the LED ball engine side and the display logic.
// No handshake: ball is sampled on every newclock edge, outputs are registered and valid every tick.
interface tennis_scoreboard_if;
    logic [15:0] ball;
    logic [3:0]  pos;
    logic        pos_valid;
    logic        dir;
    logic        hit_left;
    logic        hit_right;
    logic        point_left;
    logic        point_right;
    logic [1:0]  score_left;
    logic [1:0]  score_right;
    logic [7:0]  rally_bcd;
    logic        match_over;
    logic        match_winner;
    logic        err;
    // Debug view of the FSM: 0 = IDLE, 1 = RALLY, 2 = POINT, 3 = MATCH
    logic [1:0]  state_dbg;

    modport master (
        output ball,
        input  pos, pos_valid, dir, hit_left, hit_right, point_left, point_right,
        input  score_left, score_right, rally_bcd, match_over, match_winner, err, state_dbg
    );

    modport slave (
        input  ball,
        output pos, pos_valid, dir, hit_left, hit_right, point_left, point_right,
        output score_left, score_right, rally_bcd, match_over, match_winner, err, state_dbg
    );
endinterface

// File: rtl/tennis_scoreboard.sv
// Receive-side tennis scoreboard: decodes the one-hot LED ball bus into direction, returns,
// points, per-player scores, a BCD rally counter and the match-over banner state.
module tennis_scoreboard #(
    parameter int         WIN_POINTS = 3,
    parameter logic [7:0] RALLY_MAX  = 8'h99
) (
    input logic                 newclock,
    input logic                 reset,
    tennis_scoreboard_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RALLY = 2'd1,
        POINT = 2'd2,
        MATCH = 2'd3
    } state_t;

    localparam logic [1:0] WIN = 2'(WIN_POINTS);

    state_t      state;
    logic [3:0]  prev_pos;
    logic [3:0]  pos_q;
    logic        pos_valid_q;
    logic        dir_q;
    logic        hit_left_q;
    logic        hit_right_q;
    logic        point_left_q;
    logic        point_right_q;
    logic [1:0]  score_left_q;
    logic [1:0]  score_right_q;
    logic [7:0]  rally_q;
    logic        match_over_q;
    logic        match_winner_q;
    logic        err_q;
    logic        banner_seen;
    logic        last_left;

    logic        onehot;
    logic [3:0]  idx;
    logic        banner;
    logic        step_up;
    logic        step_dn;
    logic        stationary;
    logic        jump;

    function automatic logic [1:0] score_inc(input logic [1:0] s);
        return (s >= WIN) ? s : s + 2'd1;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v >= RALLY_MAX)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_comb begin
        onehot = 1'b0;
        idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (bus.ball == (16'h0001 << i)) begin
                onehot = 1'b1;
                idx    = 4'(i);
            end
        end
    end

    // Compare in 5 bits so that 15 -> 0 is never mistaken for an adjacent step.
    assign banner     = (bus.ball == 16'h0801) || (bus.ball == 16'h4010);
    assign step_up    = ({1'b0, idx} == ({1'b0, prev_pos} + 5'd1));
    assign step_dn    = ({1'b0, prev_pos} == ({1'b0, idx} + 5'd1));
    assign stationary = (idx == prev_pos);
    assign jump       = !(step_up || step_dn || stationary);

    always_ff @(posedge newclock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            prev_pos       <= 4'd0;
            pos_q          <= 4'd0;
            pos_valid_q    <= 1'b0;
            dir_q          <= 1'b1;
            hit_left_q     <= 1'b0;
            hit_right_q    <= 1'b0;
            point_left_q   <= 1'b0;
            point_right_q  <= 1'b0;
            score_left_q   <= 2'd0;
            score_right_q  <= 2'd0;
            rally_q        <= 8'h00;
            match_over_q   <= 1'b0;
            match_winner_q <= 1'b0;
            err_q          <= 1'b0;
            banner_seen    <= 1'b0;
            last_left      <= 1'b0;
        end else begin
            hit_left_q    <= 1'b0;
            hit_right_q   <= 1'b0;
            point_left_q  <= 1'b0;
            point_right_q <= 1'b0;
            if (onehot) begin
                pos_q       <= idx;
                pos_valid_q <= 1'b1;
                err_q       <= 1'b0;
                prev_pos    <= idx;
                if (step_up)
                    dir_q <= 1'b1;
                else if (step_dn)
                    dir_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (step_up || step_dn) begin
                            state   <= RALLY;
                            rally_q <= 8'h00;
                        end
                    end
                    RALLY: begin
                        if (dir_q && step_dn && prev_pos == 4'd15) begin
                            hit_left_q <= 1'b1;
                            rally_q    <= bcd_inc(rally_q);
                        end else if (!dir_q && step_up && prev_pos == 4'd0) begin
                            hit_right_q <= 1'b1;
                            rally_q     <= bcd_inc(rally_q);
                        end else if ((stationary && idx == 4'd15) || (jump && idx == 4'd0)) begin
                            point_right_q <= 1'b1;
                            score_right_q <= score_inc(score_right_q);
                            last_left     <= 1'b0;
                            state         <= POINT;
                        end else if ((stationary && idx == 4'd0) || (jump && idx == 4'd15)) begin
                            point_left_q <= 1'b1;
                            score_left_q <= score_inc(score_left_q);
                            last_left    <= 1'b1;
                            state        <= POINT;
                        end
                    end
                    POINT: begin
                        if ((last_left && score_left_q == WIN) || (!last_left && score_right_q == WIN)) begin
                            state          <= MATCH;
                            match_over_q   <= 1'b1;
                            match_winner_q <= last_left;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    MATCH: begin
                        // Only a banner acknowledges the finished match; without it the board stays frozen.
                        if (banner_seen) begin
                            score_left_q   <= 2'd0;
                            score_right_q  <= 2'd0;
                            rally_q        <= 8'h00;
                            match_over_q   <= 1'b0;
                            match_winner_q <= 1'b0;
                            banner_seen    <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (banner) begin
                pos_valid_q    <= 1'b0;
                err_q          <= 1'b0;
                match_over_q   <= 1'b1;
                match_winner_q <= (bus.ball == 16'h4010);
                banner_seen    <= 1'b1;
                state          <= MATCH;
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.pos          = pos_q;
    assign bus.pos_valid    = pos_valid_q;
    assign bus.dir          = dir_q;
    assign bus.hit_left     = hit_left_q;
    assign bus.hit_right    = hit_right_q;
    assign bus.point_left   = point_left_q;
    assign bus.point_right  = point_right_q;
    assign bus.score_left   = score_left_q;
    assign bus.score_right  = score_right_q;
    assign bus.rally_bcd    = rally_q;
    assign bus.match_over   = match_over_q;
    assign bus.match_winner = match_winner_q;
    assign bus.err          = err_q;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_tennis_scoreboard.sv
// Bench for tennis_scoreboard: directed vector table, hand sequences for match/banner/reset,
// and randomized ball traffic checked against an integer-level reference model.
module tb_tennis_scoreboard;
    localparam int WIN = 3;
    localparam int ST_IDLE = 0, ST_RALLY = 1, ST_POINT = 2, ST_MATCH = 3;

    typedef struct packed {
        logic [3:0] pos;
        logic       pv;
        logic       dir;
        logic       hl;
        logic       hr;
        logic       pl;
        logic       pr;
        logic [1:0] sl;
        logic [1:0] sr;
        logic [7:0] rally;
        logic       over;
        logic       win;
        logic       err;
        logic [1:0] st;
    } obs_t;

    typedef struct {
        logic [15:0] ball;
        int          pos;
        int          dir;
        int          hl;
        int          pr;
        int          sr;
        int          rally;
        int          st;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic newclock = 1'b0;
    logic reset;
    always #5 newclock = ~newclock;

    tennis_scoreboard_if bus();

    tennis_scoreboard #(.WIN_POINTS(WIN), .RALLY_MAX(8'h99)) dut (
        .newclock (newclock),
        .reset    (reset),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    obs_t exp_q[$];

    // ---------------- reference model ----------------
    int m_pos, m_prev, m_state, m_sl, m_sr, m_rally;
    bit m_pv, m_dir, m_hl, m_hr, m_pl, m_pr, m_over, m_win, m_err, m_banner;

    task automatic model_reset();
        m_pos = 0; m_prev = 0; m_state = ST_IDLE; m_sl = 0; m_sr = 0; m_rally = 0;
        m_pv = 0; m_dir = 1; m_hl = 0; m_hr = 0; m_pl = 0; m_pr = 0;
        m_over = 0; m_win = 0; m_err = 0; m_banner = 0;
    endtask

    task automatic model_step(input logic [15:0] b);
        int idx, d;
        bit old_dir;
        obs_t e;
        m_hl = 0; m_hr = 0; m_pl = 0; m_pr = 0;
        if ($countones(b) == 1) begin
            idx = 0;
            for (int i = 0; i < 16; i++) if (b[i]) idx = i;
            d = idx - m_prev;
            old_dir = m_dir;
            if (d == 1) m_dir = 1;
            else if (d == -1) m_dir = 0;
            m_pos = idx; m_pv = 1; m_err = 0;
            if (m_state == ST_IDLE) begin
                if (d == 1 || d == -1) begin m_state = ST_RALLY; m_rally = 0; end
            end else if (m_state == ST_RALLY) begin
                if (m_prev == 15 && old_dir && !m_dir) begin
                    m_hl = 1; if (m_rally < 99) m_rally++;
                end else if (m_prev == 0 && !old_dir && m_dir) begin
                    m_hr = 1; if (m_rally < 99) m_rally++;
                end else if ((d == 0 && idx == 15) || (d * d > 1 && idx == 0)) begin
                    m_pr = 1; if (m_sr < WIN) m_sr++; m_state = ST_POINT;
                end else if ((d == 0 && idx == 0) || (d * d > 1 && idx == 15)) begin
                    m_pl = 1; if (m_sl < WIN) m_sl++; m_state = ST_POINT;
                end
            end else if (m_state == ST_POINT) begin
                if (m_sl == WIN) begin m_state = ST_MATCH; m_over = 1; m_win = 1; end
                else if (m_sr == WIN) begin m_state = ST_MATCH; m_over = 1; m_win = 0; end
                else m_state = ST_IDLE;
            end else if (m_banner) begin
                m_sl = 0; m_sr = 0; m_rally = 0; m_over = 0; m_win = 0; m_banner = 0;
                m_state = ST_IDLE;
            end
            m_prev = idx;
        end else if (b == 16'h0801 || b == 16'h4010) begin
            m_pv = 0; m_err = 0; m_over = 1; m_win = (b == 16'h4010);
            m_banner = 1; m_state = ST_MATCH;
        end else begin
            m_err = 1;
        end
        e.pos = 4'(m_pos); e.pv = m_pv; e.dir = m_dir;
        e.hl = m_hl; e.hr = m_hr; e.pl = m_pl; e.pr = m_pr;
        e.sl = 2'(m_sl); e.sr = 2'(m_sr);
        e.rally = 8'(((m_rally / 10) << 4) | (m_rally % 10));
        e.over = m_over; e.win = m_win; e.err = m_err; e.st = 2'(m_state);
        exp_q.push_back(e);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        obs_t e;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("pos", bus.pos, e.pos);
        chk("pos_valid", bus.pos_valid, e.pv);
        chk("dir", bus.dir, e.dir);
        chk("hit_left", bus.hit_left, e.hl);
        chk("hit_right", bus.hit_right, e.hr);
        chk("point_left", bus.point_left, e.pl);
        chk("point_right", bus.point_right, e.pr);
        chk("score_left", bus.score_left, e.sl);
        chk("score_right", bus.score_right, e.sr);
        chk("rally_bcd", bus.rally_bcd, e.rally);
        chk("match_over", bus.match_over, e.over);
        chk("match_winner", bus.match_winner, e.win);
        chk("err", bus.err, e.err);
        chk("state", bus.state_dbg, e.st);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pos"}, bus.pos, 0);
        chk({tag, "_pos_valid"}, bus.pos_valid, 0);
        chk({tag, "_dir"}, bus.dir, 1);
        chk({tag, "_pulses"}, {bus.hit_left, bus.hit_right, bus.point_left, bus.point_right}, 0);
        chk({tag, "_scores"}, {bus.score_left, bus.score_right}, 0);
        chk({tag, "_rally"}, bus.rally_bcd, 8'h00);
        chk({tag, "_match"}, {bus.match_over, bus.match_winner}, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_state"}, bus.state_dbg, ST_IDLE);
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic [15:0] b);
        bus.ball = b;
        @(posedge newclock);
        #1;
        model_step(b);
        check_all();
    endtask

    task automatic sweep_up(input int from, input int to);
        for (int p = from; p <= to; p++) tick(16'h0001 << p);
    endtask

    task automatic sweep_down(input int from, input int to);
        for (int p = from; p >= to; p--) tick(16'h0001 << p);
    endtask

    task automatic reset_now(input string tag);
        #2 reset = 1'b1;
        #1;
        check_reset_vals(tag);
        model_reset();
        exp_q.delete();
        #1 reset = 1'b0;
    endtask

    vec_t vec[22];

    initial begin
        logic [15:0] b;
        int r, gp;
        bit gd;

        for (int i = 0; i < 3; i++) vec[i] = '{16'h0001, 0, 1, 0, 0, 0, 0, ST_IDLE};
        for (int k = 1; k <= 15; k++) vec[k + 2] = '{16'h0001 << k, k, 1, 0, 0, 0, 0, ST_RALLY};
        vec[18] = '{16'h4000, 14, 0, 1, 0, 0, 1, ST_RALLY};
        vec[19] = '{16'h8000, 15, 1, 0, 0, 0, 1, ST_RALLY};
        vec[20] = '{16'h8000, 15, 1, 0, 1, 1, 1, ST_POINT};
        vec[21] = '{16'h8000, 15, 1, 0, 0, 1, 1, ST_IDLE};

        reset = 1'b1;
        bus.ball = 16'h0000;
        model_reset();
        repeat (3) @(posedge newclock);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        // Serve from the right, first left return, then a right point.
        for (int i = 0; i < 22; i++) begin
            tick(vec[i].ball);
            chk("tbl_pos", bus.pos, vec[i].pos);
            chk("tbl_dir", bus.dir, vec[i].dir);
            chk("tbl_hit_left", bus.hit_left, vec[i].hl);
            chk("tbl_point_right", bus.point_right, vec[i].pr);
            chk("tbl_score_right", bus.score_right, vec[i].sr);
            chk("tbl_rally", bus.rally_bcd, vec[i].rally);
            chk("tbl_state", bus.state_dbg, vec[i].st);
        end

        // Right reaches three points, then banners override and a one-hot clears.
        for (int n = 0; n < 2; n++) begin
            tick(16'h4000); tick(16'h8000); tick(16'h8000); tick(16'h8000);
        end
        chk("m4_score_right", bus.score_right, 3);
        chk("m4_match_over", bus.match_over, 1);
        chk("m4_winner", bus.match_winner, 0);
        tick(16'h0801);
        chk("m4_banner_winner", bus.match_winner, 0);
        tick(16'h4010);
        chk("m4_override_winner", bus.match_winner, 1);
        tick(16'h0001);
        chk("m4_clear_scores", {bus.score_left, bus.score_right}, 0);
        chk("m4_clear_over", bus.match_over, 0);
        chk("m4_clear_state", bus.state_dbg, ST_IDLE);

        // Left point, then banner mid-rally and illegal samples.
        tick(16'h0002); tick(16'h0001); tick(16'h0001);
        chk("m5_point_left", bus.score_left, 1);
        tick(16'h0001); tick(16'h0002); tick(16'h0004);
        tick(16'h4010);
        chk("m5_banner_over", bus.match_over, 1);
        chk("m5_banner_winner", bus.match_winner, 1);
        tick(16'h0003);
        chk("m5_err_multi", bus.err, 1);
        chk("m5_score_held", bus.score_left, 1);
        tick(16'h0000);
        chk("m5_err_zero", bus.err, 1);
        tick(16'h0004);
        chk("m5_err_clear", bus.err, 0);
        chk("m5_cleared_state", bus.state_dbg, ST_IDLE);

        // Ten alternating returns, then asynchronous reset mid-rally.
        sweep_up(3, 15);
        for (int n = 0; n < 5; n++) begin
            sweep_down(14, 0);
            sweep_up(1, 15);
        end
        chk("m6_rally_10", bus.rally_bcd, 8'h10);
        sweep_down(14, 8);
        reset_now("midrally_reset");

        // Randomized ball traffic against the reference model.
        gp = 0;
        gd = 1;
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                if (gd && gp == 15) gd = 0;
                else if (!gd && gp == 0) gd = 1;
                gp = gd ? gp + 1 : gp - 1;
                b = 16'h0001 << gp;
            end else if (r < 70) begin
                b = 16'h0001 << gp;
            end else if (r < 82) begin
                gp = $urandom_range(0, 15);
                b = 16'h0001 << gp;
            end else if (r < 88) begin
                gp = ($urandom_range(0, 1) == 1) ? 15 : 0;
                b = 16'h0001 << gp;
            end else if (r < 93) begin
                b = ($urandom_range(0, 1) == 1) ? 16'h4010 : 16'h0801;
            end else begin
                b = ($urandom_range(0, 3) == 0) ? 16'h0000 : (16'($urandom) | 16'h8001);
            end
            tick(b);
        end

        // Rally counter saturation after a long exchange.
        reset_now("sat_reset");
        sweep_up(1, 15);
        for (int n = 0; n < 50; n++) begin
            sweep_down(14, 0);
            sweep_up(1, 15);
        end
        chk("rally_saturated", bus.rally_bcd, 8'h99);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
